// File: rtl/bin_div.sv
// Sequential restoring divider: 13-bit dividend by 7-bit divisor.
// One quotient bit per clock, MSB first, under a start/done handshake.
// A zero divisor completes one cycle after acceptance with an all-ones
// quotient, zero remainder and the div_by_zero flag raised.
module bin_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [12:0] dividend,
    input  logic [6:0]  divisor,
    output logic        busy,
    output logic        done,
    output logic [12:0] quotient,
    output logic [6:0]  remainder,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic [12:0] d_r, d_s;         // dividend shift register, MSB consumed first
    logic [6:0]  v_r, v_s;         // latched divisor
    logic [7:0]  r_r, r_s;         // partial remainder, one bit wider than divisor
    logic [12:0] q_r, q_s;         // quotient shift register
    logic [3:0]  count_r, count_s;
    logic        busy_s, done_s, dz_s;
    logic [12:0] quot_s;
    logic [6:0]  rem_s;
    logic [7:0]  r_shift_s;
    logic [8:0]  step_s;

    // One restoring step: returns {quotient_bit, new_partial_remainder}.
    function automatic logic [8:0] restore_step(input logic [7:0] r_shift,
                                                input logic [6:0] v);
        logic [8:0] res;
        if (r_shift >= {1'b0, v}) begin
            res = {1'b1, r_shift - {1'b0, v}};
        end else begin
            res = {1'b0, r_shift};
        end
        return res;
    endfunction

    // Next-state, datapath and output decode; everything holds by default.
    always_comb begin
        state_s   = state_r;
        d_s       = d_r;
        v_s       = v_r;
        r_s       = r_r;
        q_s       = q_r;
        count_s   = count_r;
        busy_s    = busy;
        done_s    = done;
        dz_s      = div_by_zero;
        quot_s    = quotient;
        rem_s     = remainder;
        r_shift_s = {r_r[6:0], d_r[12]};
        step_s    = restore_step(r_shift_s, v_r);
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_s = RUN;
                    d_s     = dividend;
                    v_s     = divisor;
                    r_s     = 8'd0;
                    q_s     = 13'd0;
                    count_s = 4'd0;
                    busy_s  = 1'b1;
                    done_s  = 1'b0;
                    dz_s    = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
            RUN: begin
                if (v_r == 7'd0) begin
                    state_s = DONE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    dz_s    = 1'b1;
                    quot_s  = 13'h1FFF;
                    rem_s   = 7'd0;
                end else begin
                    d_s     = {d_r[11:0], 1'b0};
                    r_s     = step_s[7:0];
                    q_s     = {q_r[11:0], step_s[8]};
                    count_s = count_r + 4'd1;
                    if (count_r == 4'd12) begin
                        state_s = DONE;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                        quot_s  = {q_r[11:0], step_s[8]};
                        rem_s   = step_s[6:0];
                    end else begin
                        state_s = RUN;
                    end
                end
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
                done_s  = 1'b0;
            end
        endcase
    end

    // State register with asynchronous abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and registered outputs; reset clears any partial result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_r         <= 13'd0;
            v_r         <= 7'd0;
            r_r         <= 8'd0;
            q_r         <= 13'd0;
            count_r     <= 4'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= 13'd0;
            remainder   <= 7'd0;
        end else begin
            d_r         <= d_s;
            v_r         <= v_s;
            r_r         <= r_s;
            q_r         <= q_s;
            count_r     <= count_s;
            busy        <= busy_s;
            done        <= done_s;
            div_by_zero <= dz_s;
            quotient    <= quot_s;
            remainder   <= rem_s;
        end
    end

endmodule

// File: tb/tb_bin_div.sv
// Self-checking bench for bin_div: directed table, multi-cycle corner
// sequences and a randomized back-to-back regression against an
// arithmetic reference model.
module tb_bin_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [12:0] dividend;
    logic [6:0]  divisor;
    logic        busy;
    logic        done;
    logic [12:0] quotient;
    logic [6:0]  remainder;
    logic        div_by_zero;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    bin_div dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend),
        .divisor(divisor), .busy(busy), .done(done), .quotient(quotient),
        .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [12:0] a;
        logic [6:0]  b;
        logic [12:0] q;
        logic [6:0]  r;
        logic        dz;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer division, all-ones quotient for a zero divisor.
    function automatic void ref_div(input int a, input int b,
                                    output int q, output int r, output int dz);
        if (b == 0) begin
            q = 8191; r = 0; dz = 1;
        end else begin
            q = a / b; r = a % b; dz = 0;
        end
    endfunction

    // One division; optional extra start pulse after intrude_at cycles of RUN.
    task automatic run_op(input logic [12:0] a, input logic [6:0] b,
                          input int intrude_at, output int lat,
                          output int busy_cnt, output int overlap);
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0;
        dividend = 13'($urandom);
        divisor  = 7'($urandom);
        lat = 0;
        overlap = 0;
        busy_cnt = busy ? 1 : 0;
        while (!done && lat < 40) begin
            if (lat == intrude_at) begin
                start = 1'b1; dividend = 13'd50; divisor = 7'd5;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
            if (busy) busy_cnt++;
            if (busy && done) overlap = 1;
        end
        start = 1'b0;
    endtask

    initial begin
        int lat, bc, ov, eq, er, edz;
        logic [12:0] na, ca;
        logic [6:0]  nb, cb;
        int last_done;

        tbl[0] = '{13'd100,  7'd7,   13'd14,   7'd2,  1'b0};
        tbl[1] = '{13'd8191, 7'd1,   13'd8191, 7'd0,  1'b0};
        tbl[2] = '{13'd5,    7'd127, 13'd0,    7'd5,  1'b0};
        tbl[3] = '{13'd8191, 7'd127, 13'd64,   7'd63, 1'b0};
        tbl[4] = '{13'd1234, 7'd0,   13'h1FFF, 7'd0,  1'b1};
        tbl[5] = '{13'd20,   7'd3,   13'd6,    7'd2,  1'b0};
        tbl[6] = '{13'd0,    7'd5,   13'd0,    7'd0,  1'b0};

        rst = 1'b1; start = 1'b0; dividend = 13'd0; divisor = 7'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_quotient", quotient, 0);
        check("reset_remainder", remainder, 0);
        check("reset_dz", div_by_zero, 0);
        @(negedge clk); rst = 1'b0;

        // Directed table
        for (int i = 0; i < 7; i++) begin
            run_op(tbl[i].a, tbl[i].b, -1, lat, bc, ov);
            check($sformatf("tbl%0d_quotient", i), quotient, tbl[i].q);
            check($sformatf("tbl%0d_remainder", i), remainder, tbl[i].r);
            check($sformatf("tbl%0d_dz", i), div_by_zero, tbl[i].dz);
            check($sformatf("tbl%0d_latency", i), lat, tbl[i].dz ? 1 : 13);
            check($sformatf("tbl%0d_busy_cycles", i), bc, tbl[i].dz ? 1 : 13);
            check($sformatf("tbl%0d_busy_done_excl", i), ov, 0);
        end

        // Start during RUN is ignored
        run_op(13'd200, 7'd9, 4, lat, bc, ov);
        check("intrude_quotient", quotient, 22);
        check("intrude_remainder", remainder, 2);
        check("intrude_latency", lat, 13);

        // Asynchronous reset mid-operation
        @(negedge clk);
        start = 1'b1; dividend = 13'd1000; divisor = 7'd33;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dz", div_by_zero, 0);
        @(negedge clk); rst = 1'b0;
        run_op(13'd1000, 7'd33, -1, lat, bc, ov);
        check("post_rst_quotient", quotient, 30);
        check("post_rst_remainder", remainder, 10);
        check("post_rst_latency", lat, 13);

        // Randomized back-to-back regression with start held high
        na = 13'($urandom_range(0, 8191));
        nb = 7'($urandom_range(1, 127));
        @(negedge clk);
        start = 1'b1; dividend = na; divisor = nb;
        @(posedge clk); #1;
        last_done = -1;
        for (int i = 0; i < 2000; i++) begin
            ca = na; cb = nb;
            na = 13'($urandom_range(0, 8191));
            nb = 7'($urandom_range(1, 127));
            dividend = na; divisor = nb;
            lat = 0;
            while (!done && lat < 40) begin
                @(posedge clk); #1;
                lat++;
            end
            ref_div(int'(ca), int'(cb), eq, er, edz);
            check("rand_timeout", lat < 40 ? 1 : 0, 1);
            check("rand_result", {quotient, remainder, div_by_zero},
                  {eq[12:0], er[6:0], edz[0]});
            check("rand_invariant",
                  ((int'(quotient) * int'(cb) + int'(remainder) == int'(ca)) &&
                   (remainder < cb)) ? 1 : 0, 1);
            if (last_done >= 0) check("rand_spacing", cyc - last_done, 14);
            last_done = cyc;
            @(posedge clk); #1;
        end
        start = 1'b0;
        repeat (20) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
